// File: rtl/mem_complete_arbiter_if.sv
// mem_complete_arbiter_if: LSQ/memory producer handshakes and the complete bus.
// master = arbiter side, slave = producers/consumer side.
interface mem_complete_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 6
);
    logic              lsq_valid;
    logic              lsq_ready;
    logic [DATA_W-1:0] lsq_data;
    logic [PC_W-1:0]   lsq_pc;
    logic [TAG_W-1:0]  lsq_tag;
    logic              mem_valid;
    logic              mem_ready;
    logic [DATA_W-1:0] mem_data;
    logic [PC_W-1:0]   mem_pc;
    logic [TAG_W-1:0]  mem_tag;
    logic              cmp_valid;
    logic              cmp_ready;
    logic [DATA_W-1:0] cmp_data;
    logic [PC_W-1:0]   cmp_pc;
    logic [TAG_W-1:0]  cmp_tag;
    logic              cmp_from_lsq;

    modport master (
        input  lsq_valid, lsq_data, lsq_pc, lsq_tag,
        input  mem_valid, mem_data, mem_pc, mem_tag, cmp_ready,
        output lsq_ready, mem_ready,
        output cmp_valid, cmp_data, cmp_pc, cmp_tag, cmp_from_lsq
    );

    modport slave (
        output lsq_valid, lsq_data, lsq_pc, lsq_tag,
        output mem_valid, mem_data, mem_pc, mem_tag, cmp_ready,
        input  lsq_ready, mem_ready,
        input  cmp_valid, cmp_data, cmp_pc, cmp_tag, cmp_from_lsq
    );
endinterface

// File: rtl/mem_complete_arbiter.sv
// mem_complete_arbiter: two per-source FIFOs arbitrated onto a registered complete bus.
// MEM_CMPL_RR_EN selects round-robin arbitration; default is fixed LSQ priority.
module mem_complete_arbiter #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 32,
    parameter int TAG_W  = 6,
    parameter int DEPTH  = 2
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    mem_complete_arbiter_if.master bus
);
    localparam int EW = DATA_W + PC_W + TAG_W;
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // index 0 = LSQ, index 1 = memory
    logic [EW-1:0] store [2][DEPTH];
    logic [EW-1:0] in_ent [2];
    logic [AW-1:0] wp [2];
    logic [AW-1:0] rp [2];
    logic [CW-1:0] cnt [2];
    logic [CW-1:0] cnt_nx [2];
    logic [1:0]    rdy, vld, push, pop, ne;
    logic          load, gl;
    logic          cmp_valid, cmp_from_lsq;
    logic [EW-1:0] cmp_ent;

    assign ne   = {cnt[1] != '0, cnt[0] != '0};
    assign load = (!cmp_valid || bus.cmp_ready) && (|ne) && !flush;

`ifdef MEM_CMPL_RR_EN
    logic last_lsq;
    assign gl = ne[0] && (!ne[1] || !last_lsq);
    always_ff @(posedge clk or negedge rstn)
        if (!rstn) last_lsq <= 1'b0;
        else if (load) last_lsq <= gl;
`else
    assign gl = ne[0];
`endif

    always_comb begin
        vld       = {bus.mem_valid, bus.lsq_valid};
        in_ent[0] = {bus.lsq_data, bus.lsq_pc, bus.lsq_tag};
        in_ent[1] = {bus.mem_data, bus.mem_pc, bus.mem_tag};
        push      = vld & rdy & {2{!flush}};
        pop       = {load && !gl, load && gl};
        for (int s = 0; s < 2; s++)
            cnt_nx[s] = cnt[s] + CW'(push[s]) - CW'(pop[s]);
    end

    always_ff @(posedge clk)
        for (int s = 0; s < 2; s++)
            if (push[s]) store[s][wp[s]] <= in_ent[s];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp           <= '{default: '0};
            rp           <= '{default: '0};
            cnt          <= '{default: '0};
            rdy          <= '0;
            cmp_valid    <= 1'b0;
            cmp_from_lsq <= 1'b0;
            cmp_ent      <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                wp[s]  <= flush ? '0 : (push[s] ? wp[s] + AW'(1) : wp[s]);
                rp[s]  <= flush ? '0 : (pop[s] ? rp[s] + AW'(1) : rp[s]);
                cnt[s] <= flush ? '0 : cnt_nx[s];
                rdy[s] <= flush || (cnt_nx[s] < CW'(DEPTH));
            end
            if (flush) begin
                cmp_valid <= 1'b0;
            end else if (load) begin
                cmp_valid    <= 1'b1;
                cmp_from_lsq <= gl;
                cmp_ent      <= gl ? store[0][rp[0]] : store[1][rp[1]];
            end else if (bus.cmp_ready) begin
                cmp_valid <= 1'b0;
            end
        end
    end

    assign bus.lsq_ready                          = rdy[0];
    assign bus.mem_ready                          = rdy[1];
    assign bus.cmp_valid                          = cmp_valid;
    assign bus.cmp_from_lsq                       = cmp_from_lsq;
    assign {bus.cmp_data, bus.cmp_pc, bus.cmp_tag} = cmp_ent;
endmodule
